si5338_i2c_master: RTL and testbench

//  Byte-level I2C master engine for Si5338 PLL access; consumes the USR_* transaction interface of the Si5338 register block.
//  One USR_trig runs one transaction:

---
 rtl/si5338_i2c_master.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_si5338_i2c_master.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/si5338_i2c_master.sv
// Byte-level I2C master for Si5338 register access: one USR_trig runs a complete
// write (dev+W, reg addr, data) or read (dev+W, reg addr, Sr, dev+R, data) transaction.
module si5338_i2c_master #(
  parameter int CLK_DIV    = 250,
  parameter int ADDR_BYTES = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        USR_trig,
  input  logic        USR_rnw,
  input  logic [7:0]  USR_wrcyc,
  input  logic [7:0]  USR_rdcyc,
  input  logic [7:0]  USR_deivce_id,
  input  logic [15:0] USR_reg_addr,
  output logic        USR_wvld,
  input  logic [7:0]  USR_wdata,
  output logic        USR_rvld,
  output logic [7:0]  USR_rdata,
  output logic        USR_error,
  output logic        USR_end,
  output logic        SCL_OE,
  output logic        SDA_OE,
  input  logic        SDA_I
);

  localparam int QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [QW-1:0] Q_LAST = QW'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_DEVW, S_REGA, S_WDAT, S_RSTART, S_DEVR, S_RDAT, S_STOP, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [QW-1:0] qcnt_q, qcnt_d;
  logic [1:0]    quar_q, quar_d;
  logic [3:0]    bit_q, bit_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          more_q, more_d;
  logic [7:0]    tx_q, tx_d;
  logic [7:0]    rx_q, rx_d;
  logic          nack_q, nack_d;
  logic          rnw_q, rnw_d;
  logic [7:0]    wrcyc_q, wrcyc_d;
  logic [7:0]    rdcyc_q, rdcyc_d;
  logic [7:0]    id_q, id_d;
  logic [15:0]   addr_q, addr_d;
  logic          err_q, err_d;
  logic          wvld_q, wvld_d;
  logic          rvld_q, rvld_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          end_q, end_d;
  logic          scl_q, scl_d;
  logic          sda_q, sda_d;

  logic q_last, slot_end, samp, byte_end, tx_byte, in_byte;

  assign q_last   = (qcnt_q == Q_LAST);
  assign slot_end = q_last && (quar_q == 2'd3);
  assign samp     = q_last && (quar_q == 2'd2);
  assign byte_end = slot_end && (bit_q == 4'd8);
  assign tx_byte  = (state_q == S_DEVW) || (state_q == S_REGA) ||
                    (state_q == S_WDAT) || (state_q == S_DEVR);
  assign in_byte  = tx_byte || (state_q == S_RDAT);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      qcnt_q  <= '0;
      quar_q  <= '0;
      bit_q   <= '0;
      cnt_q   <= '0;
      more_q  <= 1'b0;
      tx_q    <= '0;
      rx_q    <= '0;
      nack_q  <= 1'b0;
      rnw_q   <= 1'b0;
      wrcyc_q <= '0;
      rdcyc_q <= '0;
      id_q    <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
      wvld_q  <= 1'b0;
      rvld_q  <= 1'b0;
      rdata_q <= '0;
      end_q   <= 1'b0;
      scl_q   <= 1'b0;
      sda_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      qcnt_q  <= qcnt_d;
      quar_q  <= quar_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
      more_q  <= more_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      nack_q  <= nack_d;
      rnw_q   <= rnw_d;
      wrcyc_q <= wrcyc_d;
      rdcyc_q <= rdcyc_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
      wvld_q  <= wvld_d;
      rvld_q  <= rvld_d;
      rdata_q <= rdata_d;
      end_q   <= end_d;
      scl_q   <= scl_d;
      sda_q   <= sda_d;
    end
  end

  always_comb begin
    state_d = state_q;
    qcnt_d  = qcnt_q;
    quar_d  = quar_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    more_d  = more_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    nack_d  = nack_q;
    rnw_d   = rnw_q;
    wrcyc_d = wrcyc_q;
    rdcyc_d = rdcyc_q;
    id_d    = id_q;
    addr_d  = addr_q;
    err_d   = err_q;
    wvld_d  = 1'b0;
    rvld_d  = 1'b0;
    rdata_d = rdata_q;
    end_d   = 1'b0;
    scl_d   = 1'b0;
    sda_d   = 1'b0;

    if (state_q != S_IDLE && state_q != S_DONE) begin
      if (q_last) begin
        qcnt_d = '0;
        quar_d = quar_q + 2'd1;
      end else begin
        qcnt_d = qcnt_q + QW'(1);
      end
    end

    // Per-slot bit bookkeeping; byte-end transitions below override bit_d/tx_d
    if (in_byte && slot_end) begin
      bit_d = bit_q + 4'd1;
      if (bit_q < 4'd8) tx_d = {tx_q[6:0], 1'b0};
    end
    if (samp && tx_byte && bit_q == 4'd8) nack_d = SDA_I;
    if (samp && state_q == S_RDAT && bit_q < 4'd8) begin
      rx_d = {rx_q[6:0], SDA_I};
      if (bit_q == 4'd7) begin
        rvld_d  = 1'b1;
        rdata_d = {rx_q[6:0], SDA_I};
      end
    end

    case (state_q)
      S_IDLE: if (USR_trig) begin
        state_d = S_START;
        rnw_d   = USR_rnw;
        wrcyc_d = USR_wrcyc;
        rdcyc_d = USR_rdcyc;
        id_d    = USR_deivce_id & 8'hFE;
        addr_d  = USR_reg_addr;
        err_d   = 1'b0;
        qcnt_d  = '0;
        quar_d  = '0;
        bit_d   = '0;
      end
      S_START: if (slot_end) begin
        state_d = S_DEVW;
        tx_d    = id_q;
        bit_d   = '0;
      end
      S_DEVW: if (byte_end) begin
        bit_d = '0;
        if (nack_q) begin
          err_d   = 1'b1;
          state_d = S_STOP;
        end else begin
          state_d = S_REGA;
          tx_d    = (ADDR_BYTES >= 2) ? addr_q[15:8] : addr_q[7:0];
          more_d  = (ADDR_BYTES >= 2);
        end
      end
      S_REGA: if (byte_end) begin
        bit_d = '0;
        if (nack_q) begin
          err_d   = 1'b1;
          state_d = S_STOP;
        end else if (more_q) begin
          tx_d   = addr_q[7:0];
          more_d = 1'b0;
        end else if (rnw_q) begin
          state_d = (rdcyc_q == 8'd0) ? S_STOP : S_RSTART;
        end else if (wrcyc_q == 8'd0) begin
          state_d = S_STOP;
        end else begin
          state_d = S_WDAT;
          tx_d    = USR_wdata;
          wvld_d  = 1'b1;
          cnt_d   = wrcyc_q;
        end
      end
      S_WDAT: if (byte_end) begin
        bit_d = '0;
        if (nack_q) begin
          err_d   = 1'b1;
          state_d = S_STOP;
        end else if (cnt_q == 8'd1) begin
          state_d = S_STOP;
        end else begin
          tx_d   = USR_wdata;
          wvld_d = 1'b1;
          cnt_d  = cnt_q - 8'd1;
        end
      end
      S_RSTART: if (slot_end) begin
        state_d = S_DEVR;
        tx_d    = id_q | 8'h01;
        bit_d   = '0;
      end
      S_DEVR: if (byte_end) begin
        bit_d = '0;
        if (nack_q) begin
          err_d   = 1'b1;
          state_d = S_STOP;
        end else begin
          state_d = S_RDAT;
          cnt_d   = rdcyc_q;
        end
      end
      S_RDAT: if (byte_end) begin
        bit_d = '0;
        if (cnt_q == 8'd1) state_d = S_STOP;
        else cnt_d = cnt_q - 8'd1;
      end
      S_STOP: if (slot_end) state_d = S_DONE;
      S_DONE: begin
        end_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Pad drive; registered so the pins never glitch on decode changes
    case (state_q)
      S_START: sda_d = (quar_q >= 2'd2);
      S_RSTART: begin
        scl_d = (quar_q == 2'd0);
        sda_d = (quar_q >= 2'd2);
      end
      S_DEVW, S_REGA, S_WDAT, S_DEVR: begin
        scl_d = (quar_q < 2'd2);
        sda_d = (bit_q < 4'd8) ? ~tx_q[7] : 1'b0;
      end
      S_RDAT: begin
        scl_d = (quar_q < 2'd2);
        sda_d = (bit_q == 4'd8) && (cnt_q != 8'd1);
      end
      S_STOP: begin
        scl_d = (quar_q == 2'd0);
        sda_d = (quar_q != 2'd3);
      end
      default: begin
        scl_d = 1'b0;
        sda_d = 1'b0;
      end
    endcase
  end

  assign USR_wvld  = wvld_q;
  assign USR_rvld  = rvld_q;
  assign USR_rdata = rdata_q;
  assign USR_error = err_q;
  assign USR_end   = end_q;
  assign SCL_OE    = scl_q;
  assign SDA_OE    = sda_q;

endmodule

// File: tb/tb_si5338_i2c_master.sv
// Bench for si5338_i2c_master: an I2C slave model decodes the pads and a scoreboard
// compares bus tokens, read data, strobe counts and completion latency.
module tb_si5338_i2c_master;
  localparam int CLK_DIV    = 4;
  localparam int ADDR_BYTES = 2;
  localparam int TOK_S   = 256;
  localparam int TOK_P   = 512;
  localparam int TOK_ACK = 1024;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        USR_trig = 1'b0;
  logic        USR_rnw = 1'b0;
  logic [7:0]  USR_wrcyc = '0;
  logic [7:0]  USR_rdcyc = '0;
  logic [7:0]  USR_deivce_id = '0;
  logic [15:0] USR_reg_addr = '0;
  logic        USR_wvld;
  logic [7:0]  USR_wdata = '0;
  logic        USR_rvld;
  logic [7:0]  USR_rdata;
  logic        USR_error;
  logic        USR_end;
  logic        SCL_OE;
  logic        SDA_OE;
  logic        SDA_I;

  si5338_i2c_master #(.CLK_DIV(CLK_DIV), .ADDR_BYTES(ADDR_BYTES)) dut (
    .CLK(CLK), .RST(RST), .USR_trig(USR_trig), .USR_rnw(USR_rnw),
    .USR_wrcyc(USR_wrcyc), .USR_rdcyc(USR_rdcyc), .USR_deivce_id(USR_deivce_id),
    .USR_reg_addr(USR_reg_addr), .USR_wvld(USR_wvld), .USR_wdata(USR_wdata),
    .USR_rvld(USR_rvld), .USR_rdata(USR_rdata), .USR_error(USR_error),
    .USR_end(USR_end), .SCL_OE(SCL_OE), .SDA_OE(SDA_OE), .SDA_I(SDA_I)
  );

  always #5 CLK = ~CLK;

  int nerr = 0;
  int nchk = 0;
  int cyc  = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, act, act, exp, exp);
    end
  endtask

  int         exp_bus[$];
  int         exp_rd[$];
  logic [7:0] slv_rd[$];
  logic [7:0] dat[$];
  bit         nack_dev = 1'b0;
  bit         mon_en   = 1'b0;

  task automatic log_tok(input int v);
    if (exp_bus.size() == 0) chk("bus_extra", v, -1);
    else chk("bus_tok", v, exp_bus.pop_front());
  endtask

  // Open-drain slave model
  logic       pull = 1'b0;
  logic       scl_l, sda_l;
  logic       scl_p = 1'b1, sda_p = 1'b1;
  int         bitcnt = 0;
  int         byte_idx = 0;
  logic [7:0] sh = '0;
  logic [7:0] txb = '0;
  logic       rd_phase = 1'b0;
  logic       is_rd = 1'b0;
  logic       mack = 1'b0;

  assign scl_l = ~SCL_OE;
  assign SDA_I = ~(SDA_OE | pull);
  assign sda_l = SDA_I;

  always @(posedge CLK) begin
    scl_p <= scl_l;
    sda_p <= sda_l;
    if (!mon_en) begin
      bitcnt <= 0; byte_idx <= 0; rd_phase <= 1'b0; pull <= 1'b0;
    end else if (scl_p && scl_l && sda_p && !sda_l) begin
      log_tok(TOK_S);
      bitcnt <= 0; byte_idx <= 0; rd_phase <= 1'b0;
    end else if (scl_p && scl_l && !sda_p && sda_l) begin
      log_tok(TOK_P);
      bitcnt <= 0; rd_phase <= 1'b0; pull <= 1'b0;
    end else if (!scl_p && scl_l) begin
      if (bitcnt < 8) begin
        sh <= {sh[6:0], sda_l};
        bitcnt <= bitcnt + 1;
        if (bitcnt == 7 && !rd_phase) begin
          log_tok(int'({sh[6:0], sda_l}));
          if (byte_idx == 0) is_rd <= sda_l;
        end
      end else if (bitcnt == 8) begin
        bitcnt <= 9;
        if (rd_phase) begin
          log_tok(TOK_ACK + int'(sda_l));
          mack <= !sda_l;
        end
      end
    end else if (scl_p && !scl_l) begin
      if (bitcnt == 8) begin
        pull <= rd_phase ? 1'b0 : !(nack_dev && byte_idx == 0);
      end else if (bitcnt == 9) begin
        bitcnt <= 0;
        byte_idx <= byte_idx + 1;
        if ((!rd_phase && byte_idx == 0 && is_rd) || (rd_phase && mack)) begin
          rd_phase <= 1'b1;
          if (slv_rd.size() > 0) begin
            txb  <= slv_rd[0];
            pull <= ~slv_rd[0][7];
            void'(slv_rd.pop_front());
          end else begin
            txb  <= 8'hFF;
            pull <= 1'b0;
          end
        end else begin
          pull <= 1'b0;
          rd_phase <= 1'b0;
        end
      end else if (rd_phase && bitcnt >= 1 && bitcnt <= 7) begin
        pull <= ~txb[7 - bitcnt];
      end
    end
  end

  // Starts at #1 after a posedge; returns at #1 after the USR_end cycle.
  task automatic run_txn(input bit rnw, input int wr, input int rd, input logic [7:0] id,
                         input logic [15:0] addr, input bit nack, input bit retrig,
                         input int abort_at);
    int bytes, rs, s_slots, t0, nw, nr, wi;
    bit got, aborted;
    bytes = 1; rs = 0; nw = 0; nr = 0; wi = 1; got = 0; aborted = 0;
    nack_dev = nack;
    mon_en   = 1'b1;
    exp_bus.push_back(TOK_S);
    exp_bus.push_back(int'(id & 8'hFE));
    if (!nack) begin
      exp_bus.push_back(int'(addr[15:8]));
      exp_bus.push_back(int'(addr[7:0]));
      bytes = 3;
      if (rnw && rd > 0) begin
        rs = 1;
        bytes = 4 + rd;
        exp_bus.push_back(TOK_S);
        exp_bus.push_back(int'(id | 8'h01));
        for (int i = 0; i < rd; i++) begin
          exp_bus.push_back(TOK_ACK + ((i == rd - 1) ? 1 : 0));
          slv_rd.push_back(dat[i]);
          exp_rd.push_back(int'(dat[i]));
        end
      end else if (!rnw) begin
        bytes = 3 + wr;
        for (int i = 0; i < wr; i++) exp_bus.push_back(int'(dat[i]));
      end
    end
    exp_bus.push_back(TOK_P);
    s_slots = 2 + 9 * bytes + rs;

    USR_rnw = rnw; USR_wrcyc = 8'(wr); USR_rdcyc = 8'(rd);
    USR_deivce_id = id; USR_reg_addr = addr;
    USR_wdata = (!rnw && wr > 0) ? dat[0] : 8'h00;
    USR_trig = 1'b1;
    @(posedge CLK); #1;
    USR_trig = 1'b0;
    t0 = cyc;
    chk("err_cleared", int'(USR_error), 0);
    USR_rnw = ~rnw; USR_wrcyc = 8'd7; USR_rdcyc = 8'd9;
    USR_deivce_id = 8'h5A; USR_reg_addr = 16'hBEEF;

    for (int k = 1; k <= 4000 && !got; k++) begin
      @(posedge CLK); #1;
      USR_trig = (retrig && k == 100);
      if (USR_wvld) begin
        nw++;
        if (wi < wr) USR_wdata = dat[wi];
        wi++;
      end
      if (USR_rvld) begin
        nr++;
        if (exp_rd.size() == 0) chk("rdata_extra", int'(USR_rdata), -1);
        else chk("rdata", int'(USR_rdata), exp_rd.pop_front());
      end
      if (USR_end) begin
        got = 1;
        chk("end_time", cyc - t0, 1 + 4 * CLK_DIV * s_slots);
      end
      if (abort_at > 0 && nw == abort_at && !got) begin
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        mon_en = 1'b0;
        chk("rst_scl", int'(SCL_OE), 0);
        chk("rst_sda", int'(SDA_OE), 0);
        chk("rst_end", int'(USR_end), 0);
        chk("rst_wvld", int'(USR_wvld), 0);
        exp_bus.delete(); exp_rd.delete(); slv_rd.delete();
        aborted = 1;
        got = 1;
      end
    end
    USR_trig = 1'b0;
    if (!aborted) begin
      if (!got) chk("end_timeout", 0, 1);
      chk("error", int'(USR_error), int'(nack));
      chk("wvld_cnt", nw, (nack || rnw) ? 0 : wr);
      chk("rvld_cnt", nr, (!nack && rnw) ? rd : 0);
      chk("bus_left", exp_bus.size(), 0);
    end
  endtask

  task automatic idle(input int n);
    bit bad;
    bad = 0;
    repeat (n) begin
      @(posedge CLK); #1;
      if (USR_end || USR_wvld || USR_rvld || SCL_OE || SDA_OE) bad = 1;
    end
    chk("idle_quiet", int'(bad), 0);
  endtask

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_out", int'({SCL_OE, SDA_OE, USR_end, USR_wvld, USR_rvld, USR_error}), 0);
    chk("rst_rdata", int'(USR_rdata), 0);
    RST = 1'b0;
    idle(5);

    dat = '{8'h10};
    run_txn(1'b0, 1, 0, 8'hE0, 16'h00E6, 1'b0, 1'b0, 0);
    idle(10);

    dat = '{8'hA5, 8'h3C};
    run_txn(1'b1, 0, 2, 8'hE0, 16'h00E6, 1'b0, 1'b0, 0);
    chk("rdata_hold", int'(USR_rdata), 8'h3C);
    idle(10);

    dat = '{8'h55};
    run_txn(1'b0, 1, 0, 8'hE0, 16'h00E6, 1'b1, 1'b0, 0);
    idle(10);

    run_txn(1'b0, 0, 0, 8'hE0, 16'h0012, 1'b0, 1'b0, 0);
    idle(10);
    run_txn(1'b1, 0, 0, 8'hE0, 16'h0034, 1'b0, 1'b0, 0);
    idle(10);

    dat = '{8'h81, 8'h7E, 8'hC3};
    run_txn(1'b0, 3, 0, 8'hE1, 16'h1234, 1'b0, 1'b0, 0);
    idle(10);

    dat = '{8'h00};
    run_txn(1'b0, 1, 0, 8'hE0, 16'h00E6, 1'b1, 1'b1, 0);
    dat = '{8'h96};
    run_txn(1'b0, 1, 0, 8'hE0, 16'h0101, 1'b0, 1'b0, 0);
    idle(10);

    dat = '{8'h11, 8'h22, 8'h33};
    run_txn(1'b0, 3, 0, 8'hE0, 16'h00E6, 1'b0, 1'b0, 2);
    idle(60);

    dat = '{8'h10};
    run_txn(1'b0, 1, 0, 8'hE0, 16'h00E6, 1'b0, 1'b0, 0);
    idle(5);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
